fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Read-side consumer for the team's 16×8 synchronous FIFO. It pops one byte at a time through the FIFO read port and serializes each byte onto a single UART line as an 8N1 frame, LSB first, at a fixed clocks-per-bit rate. It is the drain end of the FIFO in the lab datapath: the producer writes through `w_en`/`data_w`, and this block alone drives `r_en`.

## Interface
- `CLK_DIV`, default 16: clock cycles per UART bit; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data_r`  in  8  FIFO read data; valid during the cycle after `fifo_r_en` was high, otherwise undefined/high-Z.
- `fifo_r_en`  out  1  FIFO read enable; registered, one-cycle pulse per byte.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high from FETCH through the end of STOP.
- `byte_done`  out  1  one-cycle pulse in the last cycle of STOP.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, [PARITY], STOP.
- IDLE: `tx`=1. If `fifo_empty`=0, go to FETCH.
- FETCH: one cycle with `fifo_r_en`=1, then go to LOAD.
- LOAD: one cycle. Capture `fifo_data_r` into an 8-bit shift register at the end of the cycle. Go to START.
- START: `tx`=0 for `CLK_DIV` cycles.
- DATA: 8 bits, LSB first, each held `CLK_DIV` cycles. A 3-bit counter tracks the bit index; shift right after each bit.
- STOP: `tx`=1 for `CLK_DIV` cycles. `byte_done`=1 in the final cycle. Next state is FETCH if `fifo_empty`=0 in that final cycle, else IDLE.
- Bit timer: counter of width $clog2(CLK_DIV). It reloads to 0 on each state entry, and the bit ends when the count reaches `CLK_DIV`-1.
- `fifo_r_en` is never asserted while `fifo_empty`=1, and never asserted outside FETCH.
- Reset in any state:
  - At the next edge: state=IDLE, `tx`=1, `fifo_r_en`=0, `busy`=0, `byte_done`=0, counters cleared.
  - Any in-flight byte is discarded. It has already been popped and is not re-read.
- Reset values of all outputs: `tx`=1, `fifo_r_en`=0, `busy`=0, `byte_done`=0.

## Timing
- Cycle numbering starts at cycle 0, IDLE with `fifo_empty`=0:
  - Cycle 1: FETCH, `fifo_r_en`=1.
  - Cycle 2: LOAD, data captured.
  - Cycle 3: `tx` falls for the start bit.
- Frame length: 10·`CLK_DIV` cycles, or 11·`CLK_DIV` with parity.
- Back-to-back frames: exactly 2 cycles of `tx`=1 (FETCH, LOAD) between the end of one STOP and the next start bit.
- `fifo_empty` is sampled only in IDLE and in the last STOP cycle. Changes at any other time have no effect on the current frame.
- `busy` rises in the FETCH cycle and falls in the first cycle after STOP.

## Configuration
- Macro: `FIFO_UART_TX_PARITY_EN`.
- Defined: the PARITY state sits between DATA and STOP. It sends an even-parity bit (XOR of the 8 data bits) for `CLK_DIV` cycles. Frame is 11 bits.
- Undefined: the PARITY state, its logic and its encoding are absent. DATA goes directly to STOP. Frame is 10 bits.

## Structure
- Shared package `fifo_uart_pkg`:
  - State enum `tx_state_t`.
  - Constants `DATA_BITS`=8 and `FIFO_DW`=8.
- Sub-module `uart_baud_gen`:
  - Parameter `CLK_DIV`; inputs `clk`, `rst`, `restart`; output `bit_end` (one-cycle pulse every `CLK_DIV` cycles after `restart`).
  - The FSM drives `restart` on each state entry.

## Test plan
- Single byte, `CLK_DIV`=4: write 0xA5 into an empty FIFO -> `fifo_r_en` pulses once. `tx` then gives start 0, bits 1,0,1,0,0,1,0,1, stop 1, each held 4 cycles. `byte_done` pulses once and `busy` returns to 0.
- Back-to-back: preload 0x00 and 0xFF -> two consecutive frames with exactly 2 idle-high cycles between them, 2 `fifo_r_en` pulses, and the FIFO ends empty.
- Empty guard: hold `fifo_empty`=1 for 200 cycles -> `fifo_r_en`=0, `tx`=1, `busy`=0 throughout.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0x3C -> at the next edge `tx`=1 and `busy`=0. After release with the FIFO empty, no further frame is sent.
- Full FIFO drain: 16 bytes 0x00..0x0F -> 16 frames in order, and the FIFO reports empty after the 16th FETCH.
- Parity build, `CLK_DIV`=4: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; each frame is 44 cycles long.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the state encoding.
package fifo_uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int FIFO_DW   = 8;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

    function automatic logic even_parity(input logic [FIFO_DW-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit timer: counts 0..CLK_DIV-1 and pulses bit_end on the last count.
// restart holds the count at zero so the next state starts a fresh bit.
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = !restart && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the 16x8 FIFO one byte at a time and sends each as an 8N1 UART frame.
// Build with FIFO_UART_TX_PARITY_EN to append an even-parity bit (8E1).
//
// state  | meaning
// IDLE   | line high, waiting for FIFO non-empty
// FETCH  | one-cycle FIFO read pulse
// LOAD   | capture FIFO read data into the shift register
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even-parity bit (parity build only)
// STOP   | stop bit (1); last cycle decides FETCH or IDLE
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_empty,
    input  logic [FIFO_DW-1:0] fifo_data_r,
    output logic               fifo_r_en,
    output logic               tx,
    output logic               busy,
    output logic               byte_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t          state_q;
    logic [FIFO_DW-1:0] shift_q;
    logic [2:0]         bit_idx_q;
    logic               tx_q;
    logic               r_en_q;
    logic               busy_q;
    logic               restart_q;
    logic               bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic               parity_q;
`endif

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_q),
        .bit_end (bit_end)
    );

    // restart_q is held through IDLE/FETCH/LOAD so the timer is at zero on entry to START;
    // afterwards the timer's wrap lines up with every later state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            r_en_q    <= 1'b0;
            busy_q    <= 1'b0;
            restart_q <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q      <= 1'b1;
                    restart_q <= 1'b1;
                    if (!fifo_empty) begin
                        state_q <= ST_FETCH;
                        r_en_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_en_q  <= 1'b0;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_q   <= fifo_data_r;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_q  <= even_parity(fifo_data_r);
`endif
                    tx_q      <= 1'b0;
                    restart_q <= 1'b0;
                    state_q   <= ST_START;
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        restart_q <= 1'b1;
                        if (!fifo_empty) begin
                            state_q <= ST_FETCH;
                            r_en_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    tx_q      <= 1'b1;
                    r_en_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    restart_q <= 1'b1;
                end
            endcase
        end
    end

    assign fifo_r_en = r_en_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign byte_done = (state_q == ST_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural 16x8 FIFO on the read side.
// Honours FIFO_UART_TX_PARITY_EN to expect 11-bit frames.
module tb_fifo_uart_tx;

    localparam int CLK_DIV = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_data_r = 8'h00;
    logic       fifo_r_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    logic [7:0] mem [0:255];
    int wptr = 0;
    int rptr = 0;
    int rd_count = 0;
    int bad_rd = 0;
    int asserts = 0;
    int fails = 0;

    fifo_uart_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_data_r (fifo_data_r),
        .fifo_r_en   (fifo_r_en),
        .tx          (tx),
        .busy        (busy),
        .byte_done   (byte_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wptr == rptr);

    always @(posedge clk) begin
        if (fifo_r_en) begin
            rd_count <= rd_count + 1;
            if (wptr == rptr) begin
                bad_rd <= bad_rd + 1;
            end else begin
                fifo_data_r <= mem[rptr[7:0]];
                rptr <= rptr + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] b);
        mem[wptr[7:0]] = b;
        wptr = wptr + 1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Entered at the negedge of the first start-bit cycle; leaves at the first cycle after STOP.
    task automatic check_frame(input logic [7:0] b);
        logic et;
        for (int k = 0; k < FRAME; k++) begin
            et = exp_bit(b, k / CLK_DIV);
            asserts++;
            if (tx !== et) begin
                fails++;
                $display("FAIL frame_tx byte=%02h cycle=%0d got=%b exp=%b", b, k, tx, et);
            end
            asserts++;
            if (byte_done !== (k == FRAME - 1)) begin
                fails++;
                $display("FAIL frame_byte_done byte=%02h cycle=%0d got=%b exp=%b", b, k, byte_done, (k == FRAME - 1));
            end
            asserts++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL frame_busy byte=%02h cycle=%0d got=%b exp=1", b, k, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_gap();
        for (int g = 0; g < 2; g++) begin
            asserts++;
            if (tx !== 1'b1 || busy !== 1'b1 || fifo_r_en !== (g == 0)) begin
                fails++;
                $display("FAIL gap cycle=%0d got tx=%b busy=%b r_en=%b exp tx=1 busy=1 r_en=%b", g, tx, busy, fifo_r_en, (g == 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (tx !== 1'b0) begin
            fails++;
            $display("FAIL wait_start timeout got tx=%b exp=0", tx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        asserts++;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got=%b exp=1", tx); end
        asserts++;
        if (fifo_r_en !== 1'b0) begin fails++; $display("FAIL reset_r_en got=%b exp=0", fifo_r_en); end
        asserts++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        asserts++;
        if (byte_done !== 1'b0) begin fails++; $display("FAIL reset_byte_done got=%b exp=0", byte_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int rd0;
        rd0 = rd_count;
        push(8'hA5);
        @(negedge clk);
        asserts++;
        if (fifo_r_en !== 1'b1 || busy !== 1'b1 || tx !== 1'b1) begin
            fails++;
            $display("FAIL single_fetch got r_en=%b busy=%b tx=%b exp 1 1 1", fifo_r_en, busy, tx);
        end
        @(negedge clk);
        asserts++;
        if (fifo_r_en !== 1'b0 || busy !== 1'b1 || tx !== 1'b1) begin
            fails++;
            $display("FAIL single_load got r_en=%b busy=%b tx=%b exp 0 1 1", fifo_r_en, busy, tx);
        end
        @(negedge clk);
        check_frame(8'hA5);
        asserts++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL single_after got busy=%b tx=%b exp 0 1", busy, tx);
        end
        asserts++;
        if (rd_count - rd0 !== 1) begin
            fails++;
            $display("FAIL single_reads got=%0d exp=1", rd_count - rd0);
        end
    endtask

    task automatic test_empty_guard();
        int errs;
        int rd0;
        errs = 0;
        rd0 = rd_count;
        for (int i = 0; i < 200; i++) begin
            if (fifo_r_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
            @(negedge clk);
        end
        asserts++;
        if (errs != 0) begin
            fails++;
            $display("FAIL empty_guard bad_cycles got=%0d exp=0", errs);
        end
        asserts++;
        if (rd_count != rd0) begin
            fails++;
            $display("FAIL empty_guard_reads got=%0d exp=0", rd_count - rd0);
        end
    endtask

    task automatic test_back_to_back();
        int rd0;
        rd0 = rd_count;
        push(8'h00);
        push(8'hFF);
        wait_start();
        check_frame(8'h00);
        check_gap();
        check_frame(8'hFF);
        asserts++;
        if (busy !== 1'b0 || fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL b2b_end got busy=%b empty=%b exp 0 1", busy, fifo_empty);
        end
        asserts++;
        if (rd_count - rd0 !== 2) begin
            fails++;
            $display("FAIL b2b_reads got=%0d exp=2", rd_count - rd0);
        end
    endtask

    task automatic test_reset_mid();
        int rd0;
        int errs;
        rd0 = rd_count;
        errs = 0;
        push(8'h3C);
        wait_start();
        repeat (4 * CLK_DIV + 1) @(negedge clk);
        asserts++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_bit3 got tx=%b busy=%b exp 1 1", tx, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        asserts++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_r_en !== 1'b0 || byte_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got tx=%b busy=%b r_en=%b done=%b exp 1 0 0 0", tx, busy, fifo_r_en, byte_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        asserts++;
        if (errs != 0) begin
            fails++;
            $display("FAIL mid_quiet bad_cycles got=%0d exp=0", errs);
        end
        asserts++;
        if (rd_count - rd0 !== 1) begin
            fails++;
            $display("FAIL mid_reads got=%0d exp=1", rd_count - rd0);
        end
    endtask

    task automatic test_drain();
        int rd0;
        rd0 = rd_count;
        for (int i = 0; i < 16; i++) push(8'(i));
        wait_start();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) check_gap();
            check_frame(8'(i));
        end
        asserts++;
        if (fifo_empty !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL drain_end got empty=%b busy=%b exp 1 0", fifo_empty, busy);
        end
        asserts++;
        if (rd_count - rd0 !== 16) begin
            fails++;
            $display("FAIL drain_reads got=%0d exp=16", rd_count - rd0);
        end
    endtask

    task automatic test_parity();
        push(8'hA5);
        push(8'h07);
        wait_start();
        check_frame(8'hA5);
        check_gap();
        check_frame(8'h07);
        asserts++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL parity_end got busy=%b tx=%b exp 0 1", busy, tx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty_guard();
        test_back_to_back();
        test_reset_mid();
        test_drain();
        test_parity();
        asserts++;
        if (bad_rd != 0) begin
            fails++;
            $display("FAIL read_while_empty got=%0d exp=0", bad_rd);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
